// File: rtl/mem_dump_tx.sv
// Streams a latched copy of the data-memory snapshot bus to the debug UART TX
// as a frame: header byte, data bytes (word 0 first, MSB first), XOR checksum.
module mem_dump_tx #(
   parameter int         NUM_WORDS = 10,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [32*NUM_WORDS-1:0]   memorias,
   input  logic                      tx_ready,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   output logic                      busy,
   output logic                      done
);

   localparam int NUM_BYTES = 4 * NUM_WORDS;
   localparam int IDX_W     = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE} state_t;

   state_t                         state, nextState;
   logic [NUM_WORDS-1:0][3:0][7:0] snapshot;
   logic [IDX_W-1:0]               byteIdx;
   logic [7:0]                     checksum;
   logic [7:0]                     dataByte;
   logic                           xfer;

   assign xfer = tx_valid & tx_ready;
   // Upper index bits pick the word; inverted low bits give MSB-first byte order.
   assign dataByte = snapshot[byteIdx[IDX_W-1:2]][~byteIdx[1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      tx_data   = '0;
      tx_valid  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) nextState = HDR;
         end
         HDR: begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_data  = HEADER;
            if (tx_ready) nextState = DATA;
         end
         DATA: begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_data  = dataByte;
            if (tx_ready && (byteIdx == LAST_IDX)) nextState = CSUM;
         end
         CSUM: begin
            tx_valid = 1'b1;
            busy     = 1'b1;
            tx_data  = checksum;
            if (tx_ready) nextState = DONE;
         end
         DONE: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Snapshot is captured only in IDLE so later bus changes cannot leak into a frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snapshot <= '0;
         byteIdx  <= '0;
         checksum <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  snapshot <= memorias;
                  checksum <= '0;
                  byteIdx  <= '0;
               end
            end
            HDR: begin
               if (xfer) byteIdx <= '0;
            end
            DATA: begin
               if (xfer) begin
                  checksum <= checksum ^ dataByte;
                  if (byteIdx != LAST_IDX) byteIdx <= byteIdx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: stimulus pushes the expected frame,
// a negedge monitor pops and compares every accepted byte.
module tb_mem_dump_tx;

   localparam int NW = 10;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [32*NW-1:0] memorias;
   logic            tx_ready;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            busy;
   logic            done;

   mem_dump_tx #(.NUM_WORDS(NW), .HEADER(8'hA5)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .memorias (memorias),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int          testsRun = 0;
   int          testsFailed = 0;
   logic [7:0]  expectQ[$];
   int          xferCount = 0;
   int          doneCount = 0;
   int          readyMode = 0;
   int          readyPhase = 0;
   logic [31:0] curWords[NW];
   logic        stallPending = 1'b0;
   logic [7:0]  stallData = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0: tx_ready = 1'b1;
         1: begin
            tx_ready   = (readyPhase == 0) || (readyPhase == 3);
            readyPhase = (readyPhase + 1) % 4;
         end
         default: tx_ready = ($urandom_range(0, 9) < 6);
      endcase
   end

   // Monitor: values at negedge are those the next posedge will act on.
   always @(negedge clk) begin
      if (reset) begin
         if (stallPending) begin
            check("stall_valid_held", {31'b0, tx_valid}, 32'd1);
            check("stall_data_held", {24'b0, tx_data}, {24'b0, stallData});
         end
         stallPending = tx_valid && !tx_ready;
         stallData    = tx_data;
         if (tx_valid && tx_ready) begin
            xferCount++;
            if (expectQ.size() == 0) begin
               check("unexpected_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               check("frame_byte", {24'b0, tx_data}, {24'b0, expectQ.pop_front()});
            end
         end
         if (done) doneCount++;
      end else begin
         stallPending = 1'b0;
      end
   end

   // Reference model: header, word bytes MSB first, XOR of data bytes.
   task automatic loadAndExpect();
      logic [7:0] cs;
      logic [7:0] b;
      cs = '0;
      for (int i = 0; i < NW; i++) memorias[32*i +: 32] = curWords[i];
      expectQ.push_back(8'hA5);
      for (int w = 0; w < NW; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(curWords[w] >> (8 * (3 - k)));
            expectQ.push_back(b);
            cs = cs ^ b;
         end
      end
      expectQ.push_back(cs);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int bound, output int cycles);
      cycles = 0;
      while (!done && cycles < bound) begin
         @(posedge clk); #1;
         cycles++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
      check("done_busy_low", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic runFrame(input string name, input bit timed, input bit clobber);
      int cyc;
      int d0;
      check({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
      loadAndExpect();
      d0 = doneCount;
      pulseStart();
      check({name, "_busy_up"}, {31'b0, busy}, 32'd1);
      check({name, "_valid_up"}, {31'b0, tx_valid}, 32'd1);
      check({name, "_header"}, {24'b0, tx_data}, 32'hA5);
      if (clobber) begin
         @(posedge clk); #1;
         memorias = '0;
      end
      waitDone(3000, cyc);
      if (timed) check({name, "_latency"}, 32'(cyc), 32'd42);
      check({name, "_queue_empty"}, 32'(expectQ.size()), 32'd0);
      check({name, "_done_count"}, 32'(doneCount - d0), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int x0;
      int cyc;
      reset    = 1'b0;
      start    = 1'b0;
      tx_ready = 1'b1;
      memorias = '0;
      #1;
      check("reset_tx_data", {24'b0, tx_data}, 32'd0);
      check("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic dump
      for (int i = 0; i < NW; i++) curWords[i] = 32'h1122_3300 + 32'(i);
      runFrame("basic", 1'b1, 1'b0);

      // Backpressure 1,0,0,1
      readyMode  = 1;
      readyPhase = 0;
      runFrame("backpressure", 1'b0, 1'b0);
      readyMode = 0;
      @(posedge clk); #1;

      // Snapshot isolation
      for (int i = 0; i < NW; i++) curWords[i] = 32'hDEAD_BEEF;
      runFrame("snapshot", 1'b0, 1'b1);

      // All-zero memory
      for (int i = 0; i < NW; i++) curWords[i] = 32'h0;
      runFrame("zero", 1'b1, 1'b0);

      // Start while busy: pulses at cycles 0, 5, 43; new frame at 45
      for (int i = 0; i < NW; i++) curWords[i] = $urandom;
      loadAndExpect();
      d0 = doneCount;
      for (int c = 0; c <= 44; c++) begin
         start = (c == 0) || (c == 5) || (c == 43);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("busy_start_idle", {31'b0, busy}, 32'd0);
      check("busy_start_novalid", {31'b0, tx_valid}, 32'd0);
      check("busy_start_one_done", 32'(doneCount - d0), 32'd1);
      check("busy_start_queue", 32'(expectQ.size()), 32'd0);
      for (int i = 0; i < NW; i++) curWords[i] = $urandom;
      runFrame("restart", 1'b1, 1'b0);

      // Reset mid-frame
      for (int i = 0; i < NW; i++) curWords[i] = $urandom;
      loadAndExpect();
      d0 = doneCount;
      x0 = xferCount;
      pulseStart();
      cyc = 0;
      while ((xferCount - x0) < 18 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("reset_reached_byte17", {31'b0, ((xferCount - x0) >= 18)}, 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("midreset_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("midreset_busy", {31'b0, busy}, 32'd0);
      check("midreset_done", {31'b0, done}, 32'd0);
      check("midreset_tx_data", {24'b0, tx_data}, 32'd0);
      expectQ.delete();
      @(posedge clk); @(posedge clk); #1;
      check("midreset_no_done", 32'(doneCount - d0), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      runFrame("post_reset", 1'b1, 1'b0);

      // Randomized frames under random backpressure
      readyMode = 2;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < NW; i++) curWords[i] = $urandom;
         runFrame("random", 1'b0, 1'b0);
      end
      readyMode = 0;
      @(posedge clk); #1;

      check("final_queue_empty", 32'(expectQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
